// File: rtl/spin_tick_gen.sv
// Spin-animation rate stage: debounced run/pause and single-step keys, and a registered
// one-cycle tick every CLK_HZ >> speed cycles while running, or one tick per step press while paused.
module spin_tick_gen #(
   parameter int unsigned CLK_HZ          = 50000000,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] speed,
   input  logic       key_run_n,
   input  logic       key_step_n,
   output logic       tick,
   output logic       running
);

   localparam int unsigned CNT_W = $clog2(CLK_HZ);
   localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LIM0    = CNT_W'(CLK_HZ - 1);
   localparam logic [CNT_W-1:0] LIM1    = CNT_W'((CLK_HZ >> 1) - 1);
   localparam logic [CNT_W-1:0] LIM2    = CNT_W'((CLK_HZ >> 2) - 1);
   localparam logic [CNT_W-1:0] LIM3    = CNT_W'((CLK_HZ >> 3) - 1);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } state_t;

   // Key conditioning, bit 0 = run key, bit 1 = step key.
   logic [1:0]      key_n;
   logic [1:0]      sync1_q;
   logic [1:0]      sync2_q;
   logic [1:0]      level_q;
   logic [1:0]      level_d;
   logic [1:0]      level_prev_q;
   logic [1:0]      press;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];
   logic            run_evt;
   logic            step_evt;

   // Period / state machine.
   state_t          state_q;
   state_t          state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] limit;
   logic            tick_q;
   logic            tick_d;
   logic            running_q;
   logic            running_d;

   assign key_n = {key_step_n, key_run_n};

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         db_cnt_d[k] = '0;
         level_d[k]  = level_q[k];
         if (sync2_q[k] != level_q[k]) begin
            if (db_cnt_q[k] == DB_LAST) begin
               level_d[k] = sync2_q[k];
            end else begin
               db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= '1;
         sync2_q      <= '1;
         level_q      <= '1;
         level_prev_q <= '1;
         for (int k = 0; k < 2; k++) begin
            db_cnt_q[k] <= '0;
         end
      end else begin
         sync1_q      <= key_n;
         sync2_q      <= sync1_q;
         level_q      <= level_d;
         level_prev_q <= level_q;
         for (int k = 0; k < 2; k++) begin
            db_cnt_q[k] <= db_cnt_d[k];
         end
      end
   end

   // A press is the cycle after the debounced level falls; releases are ignored.
   assign press    = level_prev_q & ~level_q;
   assign run_evt  = press[0];
   assign step_evt = press[1];

   // speed is a quasi-static switch, used without synchronisation.
   always_comb begin
      limit = LIM0;
      case (speed)
         2'd0:    limit = LIM0;
         2'd1:    limit = LIM1;
         2'd2:    limit = LIM2;
         2'd3:    limit = LIM3;
         default: limit = LIM0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         running_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         running_q <= running_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (run_evt) state_d = ST_PAUSE;
         ST_PAUSE: if (run_evt) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // The >= compare lets a speed-up mid-period wrap at once instead of overrunning the counter.
   always_comb begin
      cnt_d  = '0;
      tick_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (!run_evt) begin
               if (cnt_q >= limit) begin
                  tick_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_PAUSE: begin
            tick_d = step_evt & ~run_evt;
         end
         default: begin
            tick_d = 1'b0;
         end
      endcase
      running_d = (state_d == ST_RUN);
   end

   assign tick    = tick_q;
   assign running = running_q;

endmodule

// File: tb/tb_spin_tick_gen.sv
// Randomised and directed bench for spin_tick_gen with a cycle-level behavioural model
// built from key sample history, run lengths and an elapsed-cycle count.
module tb_spin_tick_gen;

   localparam int CLK_HZ = 16;
   localparam int DEB    = 4;

   logic       clock      = 1'b0;
   logic       reset_n    = 1'b0;
   logic [1:0] speed      = 2'd0;
   logic       key_run_n  = 1'b1;
   logic       key_step_n = 1'b1;
   logic       tick;
   logic       running;

   int checks = 0;
   int errors = 0;
   int win_ticks;
   int win_mis;

   spin_tick_gen #(
      .CLK_HZ          (CLK_HZ),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .speed      (speed),
      .key_run_n  (key_run_n),
      .key_step_n (key_step_n),
      .tick       (tick),
      .running    (running)
   );

   always #5 clock = ~clock;

   // Reference model: keys seen two samples late; a new level is accepted after DEB
   // consecutive samples of it; a press acts one cycle after the accepted fall.
   bit mq_run[$];
   bit mq_step[$];
   bit m_last_s [2];
   int m_len    [2];
   bit m_deb    [2];
   bit m_pend   [2];
   bit m_tick;
   bit m_running;
   int m_elapsed;

   always @(posedge clock or negedge reset_n) begin : model
      bit s   [2];
      bit evt [2];
      int period;
      if (!reset_n) begin
         mq_run.delete();
         mq_step.delete();
         repeat (2) begin
            mq_run.push_back(1'b1);
            mq_step.push_back(1'b1);
         end
         for (int k = 0; k < 2; k++) begin
            m_last_s[k] = 1'b1;
            m_len[k]    = 0;
            m_deb[k]    = 1'b1;
            m_pend[k]   = 1'b0;
         end
         m_tick    = 1'b0;
         m_running = 1'b1;
         m_elapsed = 0;
      end else begin
         s[0] = mq_run.pop_front();
         mq_run.push_back(key_run_n);
         s[1] = mq_step.pop_front();
         mq_step.push_back(key_step_n);
         for (int k = 0; k < 2; k++) begin
            evt[k]      = m_pend[k];
            m_len[k]    = (s[k] == m_last_s[k]) ? m_len[k] + 1 : 1;
            m_last_s[k] = s[k];
            m_pend[k]   = 1'b0;
            if (s[k] != m_deb[k] && m_len[k] >= DEB) begin
               m_pend[k] = (s[k] == 1'b0);
               m_deb[k]  = s[k];
            end
         end
         period = CLK_HZ >> speed;
         m_tick = 1'b0;
         if (evt[0]) begin
            m_running = !m_running;
            m_elapsed = 0;
         end else if (m_running) begin
            if (m_elapsed >= period - 1) begin
               m_tick    = 1'b1;
               m_elapsed = 0;
            end else begin
               m_elapsed = m_elapsed + 1;
            end
         end else begin
            m_tick = evt[1];
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (tick) win_ticks++;
         if (tick !== m_tick || running !== m_running) win_mis++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (running !== 1'b1) begin
         errors++;
         $display("FAIL reset_running: got %b want 1", running);
      end
      checks++;
      if (tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick: got %b want 0", tick);
      end
   endtask

   task automatic test_free_run();
      int first;
      first = -1;
      reset_n = 1'b1;
      for (int i = 1; i <= 40 && first < 0; i++) begin
         @(negedge clock);
         if (tick) first = i;
      end
      checks++;
      if (first !== 16) begin
         errors++;
         $display("FAIL free_first_tick: got cycle %0d want 16", first);
      end
      win_ticks = 0;
      win_mis   = 0;
      run_cycles(64);
      checks++;
      if (win_ticks !== 4 || win_mis !== 0) begin
         errors++;
         $display("FAIL free_speed0: ticks %0d mism %0d want 4 and 0", win_ticks, win_mis);
      end
      speed     = 2'd3;
      win_ticks = 0;
      win_mis   = 0;
      run_cycles(20);
      checks++;
      if (win_ticks !== 10 || win_mis !== 0 || running !== 1'b1) begin
         errors++;
         $display("FAIL free_speed3: ticks %0d mism %0d running %b want 10 0 1", win_ticks, win_mis, running);
      end
      speed = 2'd0;
      run_cycles(20);
   endtask

   task automatic test_bounce();
      int lat;
      int base;
      int first;
      win_ticks = 0;
      win_mis   = 0;
      for (int r = 0; r < 10; r++) begin
         key_run_n = 1'b0;
         run_cycles(3);
         key_run_n = 1'b1;
         run_cycles(1);
      end
      checks++;
      if (running !== 1'b1 || win_mis !== 0) begin
         errors++;
         $display("FAIL bounce_reject: running %b mism %0d want 1 and 0", running, win_mis);
      end
      lat = -1;
      key_run_n = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (lat < 0 && running === 1'b0) lat = i;
      end
      key_run_n = 1'b1;
      checks++;
      if (lat < DEB + 2 || lat > DEB + 4) begin
         errors++;
         $display("FAIL bounce_press_latency: got %0d want %0d +-1", lat, DEB + 3);
      end
      win_ticks = 0;
      win_mis   = 0;
      run_cycles(100);
      checks++;
      if (win_ticks !== 0 || running !== 1'b0 || win_mis !== 0) begin
         errors++;
         $display("FAIL bounce_paused: ticks %0d running %b mism %0d want 0 0 0", win_ticks, running, win_mis);
      end
      base  = -1;
      first = -1;
      key_run_n = 1'b0;
      for (int i = 1; i <= 60 && first < 0; i++) begin
         @(negedge clock);
         if (i == 10) key_run_n = 1'b1;
         if (base < 0 && running === 1'b1) base = i;
         if (base >= 0 && tick === 1'b1) first = i - base;
      end
      key_run_n = 1'b1;
      checks++;
      if (base < DEB + 2 || base > DEB + 4 || first !== CLK_HZ) begin
         errors++;
         $display("FAIL bounce_resume: entry %0d first tick %0d want %0d+-1 and %0d", base, first, DEB + 3, CLK_HZ);
      end
   endtask

   task automatic test_step();
      int last;
      int nt;
      int gaps_bad;
      key_run_n = 1'b0;
      run_cycles(10);
      key_run_n = 1'b1;
      run_cycles(10);
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL step_pause: running %b want 0", running);
      end
      win_ticks = 0;
      win_mis   = 0;
      for (int p = 0; p < 3; p++) begin
         key_step_n = 1'b0;
         run_cycles(6);
         key_step_n = 1'b1;
         run_cycles(10);
      end
      checks++;
      if (win_ticks !== 3 || win_mis !== 0) begin
         errors++;
         $display("FAIL step_three: ticks %0d mism %0d want 3 and 0", win_ticks, win_mis);
      end
      win_ticks = 0;
      win_mis   = 0;
      key_step_n = 1'b0;
      run_cycles(50);
      key_step_n = 1'b1;
      run_cycles(10);
      checks++;
      if (win_ticks !== 1 || running !== 1'b0 || win_mis !== 0) begin
         errors++;
         $display("FAIL step_hold: ticks %0d running %b mism %0d want 1 0 0", win_ticks, running, win_mis);
      end
      key_run_n = 1'b0;
      run_cycles(10);
      key_run_n = 1'b1;
      run_cycles(10);
      last     = -1;
      nt       = 0;
      gaps_bad = 0;
      for (int i = 1; i <= 120; i++) begin
         @(negedge clock);
         key_step_n = ((i % 16) < 8) ? 1'b0 : 1'b1;
         if (tick === 1'b1) begin
            if (last >= 0 && (i - last) != CLK_HZ) gaps_bad++;
            last = i;
            nt++;
         end
      end
      key_step_n = 1'b1;
      checks++;
      if (gaps_bad !== 0 || nt < 6 || running !== 1'b1) begin
         errors++;
         $display("FAIL step_in_run: bad gaps %0d ticks %0d running %b want 0 >=6 1", gaps_bad, nt, running);
      end
   endtask

   task automatic test_speed_change();
      int first;
      first = -1;
      speed = 2'd0;
      for (int i = 1; i <= 40 && first < 0; i++) begin
         @(negedge clock);
         if (tick === 1'b1) first = i;
      end
      checks++;
      if (first < 0) begin
         errors++;
         $display("FAIL speed_sync: no tick within 40 cycles, want one");
      end
      repeat (10) @(negedge clock);
      speed = 2'd2;
      @(negedge clock);
      checks++;
      if (tick !== 1'b1) begin
         errors++;
         $display("FAIL speed_up_immediate: tick %b want 1", tick);
      end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clock);
         checks++;
         if (tick !== ((i % 4) == 0)) begin
            errors++;
            $display("FAIL speed_up_cadence: offset %0d tick %b want %b", i, tick, (i % 4) == 0);
         end
      end
      @(negedge clock);
      speed = 2'd0;
      first = -1;
      for (int i = 1; i <= 30 && first < 0; i++) begin
         @(negedge clock);
         if (tick === 1'b1) first = i;
      end
      checks++;
      if (first !== 15) begin
         errors++;
         $display("FAIL speed_down: next tick after %0d cycles want 15", first);
      end
   endtask

   task automatic test_simultaneous();
      key_run_n = 1'b0;
      run_cycles(10);
      key_run_n = 1'b1;
      run_cycles(10);
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL simul_pause: running %b want 0", running);
      end
      win_ticks = 0;
      win_mis   = 0;
      key_run_n  = 1'b0;
      key_step_n = 1'b0;
      run_cycles(10);
      key_run_n  = 1'b1;
      key_step_n = 1'b1;
      run_cycles(10);
      checks++;
      if (running !== 1'b1 || win_ticks !== 0 || win_mis !== 0) begin
         errors++;
         $display("FAIL simul_run_wins: running %b ticks %0d mism %0d want 1 0 0", running, win_ticks, win_mis);
      end
   endtask

   task automatic test_random();
      int hold_r;
      int hold_s;
      hold_r    = 1;
      hold_s    = 1;
      win_ticks = 0;
      win_mis   = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clock);
         if (tick) win_ticks++;
         if (tick !== m_tick || running !== m_running) win_mis++;
         hold_r--;
         if (hold_r == 0) begin
            key_run_n = ~key_run_n;
            hold_r    = (key_run_n == 1'b0) ? int'($urandom_range(1, 9)) : int'($urandom_range(8, 60));
         end
         hold_s--;
         if (hold_s == 0) begin
            key_step_n = ~key_step_n;
            hold_s     = int'($urandom_range(1, 12));
         end
         if ($urandom_range(0, 63) == 0) speed = 2'($urandom_range(0, 3));
      end
      key_run_n  = 1'b1;
      key_step_n = 1'b1;
      checks++;
      if (win_mis !== 0 || win_ticks == 0) begin
         errors++;
         $display("FAIL random_model: mismatches %0d ticks %0d want 0 and >0", win_mis, win_ticks);
      end
   endtask

   task automatic test_reset_mid();
      int first;
      speed = 2'd0;
      run_cycles(20);
      if (running === 1'b1) begin
         key_run_n = 1'b0;
         run_cycles(10);
         key_run_n = 1'b1;
         run_cycles(10);
      end
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_paused: running %b want 0", running);
      end
      key_step_n = 1'b0;
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (running !== 1'b1 || tick !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async: running %b tick %b want 1 0", running, tick);
      end
      key_step_n = 1'b1;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      first = -1;
      for (int i = 1; i <= 40 && first < 0; i++) begin
         @(negedge clock);
         if (tick === 1'b1) first = i;
      end
      checks++;
      if (first !== 16 || running !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_first_tick: cycle %0d running %b want 16 1", first, running);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_bounce();
      test_step();
      test_speed_change();
      test_simultaneous();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
